// File: rtl/aes_encrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_encrypt_iter
// Iterative AES-128 encryption core. One cipher round is computed per clock,
// and the round key is derived on the fly from the previous round key, so no
// expanded key schedule is stored. Only ROUNDS = 10 (AES-128) is meaningful.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       launch request, sampled only while idle
//   plaintext   input block, bit 127 = byte 0 (FIPS-197 order)
//   key         cipher key, same byte order
//   busy        high while rounds are in progress
//   done        one-cycle pulse when ciphertext is updated
//   ciphertext  last completed result, held until the next completion
// ---------------------------------------------------------------------------
module aes_encrypt_iter #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        for (int unsigned i = 0; i < 16; i++)
            sub_bytes[8*i +: 8] = sbox(s[8*i +: 8]);
    endfunction

    // Byte index n = 4*col + row; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                shift_rows[8*(15 - (4*c + r)) +: 8] =
                    s[8*(15 - (4*((c + r) % 4) + r)) +: 8];
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [7:0] a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[32*(3 - c) + 24 +: 8];
            a1 = s[32*(3 - c) + 16 +: 8];
            a2 = s[32*(3 - c) +  8 +: 8];
            a3 = s[32*(3 - c)      +: 8];
            mix_columns[32*(3 - c) + 24 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mix_columns[32*(3 - c) + 16 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mix_columns[32*(3 - c) +  8 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mix_columns[32*(3 - c)      +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endfunction

    // One step of the AES-128 key schedule: previous round key -> next.
    function automatic logic [127:0] key_step(input logic [127:0] rk,
                                              input logic [7:0]   rcon);
        logic [31:0] w0, w1, w2, w3, t;
        t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
        w0 = rk[127:96] ^ t ^ {rcon, 24'h0};
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        key_step = {w0, w1, w2, w3};
    endfunction

    logic [0:0]   fsm_q,   fsm_d;
    logic [3:0]   rnd_q,   rnd_d;
    logic [7:0]   rcon_q,  rcon_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q,    rk_d;
    logic [127:0] ct_q,    ct_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;

    logic [127:0] sr_w, nk_w;

    assign sr_w = shift_rows(sub_bytes(state_q));
    assign nk_w = key_step(rk_q, rcon_q);

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        state_d = state_q;
        rk_d    = rk_q;
        ct_d    = ct_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (fsm_q == IDLE) begin
            if (start) begin
                state_d = plaintext ^ key;
                rk_d    = key;
                rnd_d   = 4'd1;
                rcon_d  = 8'h01;
                busy_d  = 1'b1;
                fsm_d   = RUN;
            end
        end else begin
            if (rnd_q == LAST_RND) begin
                // Final round omits MixColumns and writes straight to the output.
                ct_d   = sr_w ^ nk_w;
                done_d = 1'b1;
                busy_d = 1'b0;
                fsm_d  = IDLE;
            end else begin
                state_d = mix_columns(sr_w) ^ nk_w;
                rk_d    = nk_w;
                rcon_d  = xtime(rcon_q);
                rnd_d   = rnd_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            rnd_q   <= '0;
            rcon_q  <= '0;
            state_q <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            ct_q    <= ct_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ciphertext = ct_q;

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
Iterative AES-128 encryption core, the forward-direction counterpart of the team's decryption datapath. It computes one round per clock and generates round keys on the fly from the cipher key, so no 1408-bit expanded key is stored. A start/busy/done handshake lets a controller or display wrapper launch a block and latch the ciphertext. It reuses the existing SubBytes and AddRoundKey leaf functions and adds forward ShiftRows, MixColumns and a single-step key schedule.

Parameters:
ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is supported, and other values are illegal.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request; sampled only while idle
plaintext  input  128  input block, bit 127 = byte 0 (FIPS-197 order); sampled on the accepting edge
key  input  128  cipher key, same byte order; sampled on the accepting edge
busy  output  1  high while rounds are in progress
done  output  1  one-cycle pulse when ciphertext is updated
ciphertext  output  128  last completed result; held until the next completion

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; round counter = 0; state and round-key registers = 0.
  - busy = 0, done = 0, ciphertext = 0.
  - Reset mid-operation aborts the block; no done pulse is produced and ciphertext returns to 0.
- FSM states: IDLE, RUN.
- IDLE:
  - On an edge with start=1, the block is accepted:
    - state <= plaintext ^ key (round 0 AddRoundKey); rk <= key; rnd <= 1; rcon <= 8'h01.
    - FSM goes to RUN; busy goes high from the next cycle.
  - With start=0, all registers hold.
- RUN, each edge:
  - nk = KeyStep(rk, rcon): w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - For rnd < ROUNDS: state <= MixColumns(ShiftRows(SubBytes(state))) ^ nk; rk <= nk; rcon <= xtime(rcon); rnd <= rnd+1.
  - For rnd == ROUNDS: ciphertext <= ShiftRows(SubBytes(state)) ^ nk (no MixColumns); done <= 1; busy <= 0; FSM goes to IDLE.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- xtime: left shift by 1, then XOR with 8'h1b if bit 7 was set (GF(2^8) mod x^8+x^4+x^3+x+1).
- Latency:
  - Edge E0 accepts start; edges E1..E10 perform rounds 1..10.
  - done is high and ciphertext is valid in the cycle following E10, i.e. 10 cycles after the start edge.
  - Throughput is one block per 11 edges.
- busy is registered: 1 from E0+ through E10, 0 while done is high.
- start while busy=1 is ignored, with no queuing.
- start during the done cycle is accepted (FSM is IDLE), giving back-to-back blocks; ciphertext still holds the previous result until the new block completes.
- plaintext and key may change freely after the accepting edge.
- rnd is 4 bits and never wraps, because RUN exits at rnd=10.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734, start for one cycle.
  - Required: internal state after E0 = 193de3bea0f4e22b9ac68d2ae9f84808; done pulse 10 cycles later; ciphertext=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff.
  - Required: ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a; done width exactly 1 cycle; busy high for exactly 10 cycles.
- Start while busy:
  - Stimulus: launch App. B, then pulse start with C.1 data at round 5.
  - Required: ignored; result=3925841d..., only one done pulse.
- Back-to-back:
  - Stimulus: assert start with C.1 data during the App. B done cycle.
  - Required: second done exactly 11 cycles after the first, with ciphertext=69c4e0d8...; the first result is held in between.
- Reset mid-run:
  - Stimulus: drive rst_n low at round 6, release, then run C.1.
  - Required: immediate busy=0, done=0, ciphertext=0; no spurious done; the subsequent C.1 run yields 69c4e0d8....
- Idle hold:
  - Stimulus: after completion, toggle plaintext and key with start=0 for 20 cycles.
  - Required: ciphertext unchanged, busy=0, done=0.
